// File: rtl/queue_pkg.sv
// Shared sizing constants and helpers for the queue/stack storage blocks.
package queue_pkg;

    localparam int QUEUE_WIDTH = 8;
    localparam int QUEUE_DEPTH = 8;

    // Pointer width for a power-of-two depth; at least one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/queue_mem.sv
// Queue storage: one synchronous write port and one asynchronous read port.
module queue_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The read is sampled into data_out by the parent at the pop edge, so a
    // same-edge write to the head slot (full push+pop) still returns the old word.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/queue.sv
// FIFO queue with registered head output, sticky overflow/underflow and sync clear.
module queue
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            data_in,
    output logic [WIDTH-1:0]            data_out,
    output logic                        out_valid,
    output logic                        empty,
    output logic                        full,
    output logic [ptr_w(DEPTH):0]       count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] head;
    logic             pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full queue still takes a push when the same edge frees the head slot.
    assign push_ok = push && (!full || pop_ok);

    queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok && !clear),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= pop_ok;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= head;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !push_ok) overflow  <= 1'b1;
            if (pop && empty)     underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_queue.sv
// Scoreboard bench for queue: behavioural FIFO model plus expected-output queue.
module tb_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push = 1'b0, pop = 1'b0, clear = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             out_valid, empty, full, overflow, underflow;
    logic [3:0]       count;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mq[$];     // model contents
    logic [WIDTH-1:0] exp_q[$];  // scoreboard of popped words awaiting out_valid
    logic [WIDTH-1:0] m_last = '0;
    logic             m_ovf = 1'b0, m_unf = 1'b0, m_ov = 1'b0;

    queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_ov   = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic c, input logic [WIDTH-1:0] d);
        logic pop_ok, push_ok;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_ov  = 1'b0;
        end else begin
            pop_ok  = q && (mq.size() > 0);
            push_ok = p && ((mq.size() < DEPTH) || pop_ok);
            if (q && mq.size() == 0) m_unf = 1'b1;
            if (p && !push_ok)       m_ovf = 1'b1;
            if (pop_ok) begin
                m_last = mq.pop_front();
                exp_q.push_back(m_last);
            end
            m_ov = pop_ok;
            if (push_ok) mq.push_back(d);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_last));
        if (out_valid) begin
            if (exp_q.size() > 0) chk({tag, ".sb"}, 32'(data_out), 32'(exp_q.pop_front()));
            else chk({tag, ".sb_extra"}, 32'(out_valid), 32'(0));
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, sample 1 later.
    task automatic cyc(input string tag, input logic p, input logic q, input logic c,
                       input logic [WIDTH-1:0] d);
        @(negedge clk);
        push = p; pop = q; clear = c; data_in = d;
        @(posedge clk);
        model_step(p, q, c, d);
        #1;
        check_state(tag);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.count", 32'(count), 32'(0));
        chk("rst.empty", 32'(empty), 32'(1));
        chk("rst.data_out", 32'(data_out), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cyc("idle", 0, 0, 0, 8'h00);

        // Basic FIFO order
        cyc("p0", 1, 0, 0, 8'hA4);
        cyc("p1", 1, 0, 0, 8'hC2);
        cyc("p2", 1, 0, 0, 8'h3F);
        for (int i = 0; i < 3; i++) cyc("pop3", 0, 1, 0, 8'h00);
        chk("fifo.data_out", 32'(data_out), 32'h3F);
        cyc("drain", 0, 0, 0, 8'h00);

        // Fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) cyc("fill", 1, 0, 0, 8'(i));
        cyc("ovf", 1, 0, 0, 8'h09);
        chk("ovf.flag", 32'(overflow), 32'(1));
        for (int i = 0; i < 8; i++) cyc("drain8", 0, 1, 0, 8'h00);
        cyc("unf", 0, 1, 0, 8'h00);
        chk("unf.hold", 32'(data_out), 32'h08);
        cyc("clr0", 0, 0, 1, 8'h00);

        // Full push+pop, then wrap
        for (int i = 1; i <= 8; i++) cyc("fill2", 1, 0, 0, 8'(i));
        cyc("fullpp", 1, 1, 0, 8'h55);
        chk("fullpp.data_out", 32'(data_out), 32'h01);
        chk("fullpp.count", 32'(count), 32'(8));
        for (int i = 0; i < 7; i++) cyc("wrap", 0, 1, 0, 8'h00);
        cyc("wrap55", 0, 1, 0, 8'h00);
        chk("wrap.data_out", 32'(data_out), 32'h55);

        // Empty push+pop: no bypass
        cyc("clr1", 0, 0, 1, 8'h00);
        cyc("emptypp", 1, 1, 0, 8'h77);
        chk("emptypp.unf", 32'(underflow), 32'(1));
        cyc("pop77", 0, 1, 0, 8'h00);
        chk("pop77.data_out", 32'(data_out), 32'h77);

        // Random mixed traffic
        for (int i = 0; i < 60; i++)
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 19) == 0), 8'($urandom));

        // Async reset mid-operation
        cyc("clr2", 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cyc("prst", 1, 0, 0, 8'(8'h10 + i));
        @(negedge clk);
        push = 0; pop = 0; clear = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst.count", 32'(count), 32'(0));
        chk("arst.empty", 32'(empty), 32'(1));
        chk("arst.data_out", 32'(data_out), 32'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc("postrst", 0, 1, 0, 8'h00);
        chk("postrst.unf", 32'(underflow), 32'(1));

        // Clear with count 5
        for (int i = 0; i < 5; i++) cyc("p5", 1, 0, 0, 8'(8'h20 + i));
        chk("p5.count", 32'(count), 32'(5));
        cyc("clr5", 1, 1, 1, 8'hEE);
        chk("clr5.count", 32'(count), 32'(0));
        cyc("tail", 0, 0, 0, 8'h00);
        chk("sb.leftover", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
